timing_gen: RTL and testbench

Machine-cycle timing generator for the 4004 core. It sits directly upstream of the ALU, register and instruction-decode boards. It divides `sysclk` into the two-phase `clk1`/`clk2` clocks and sequences the eight machine states A1 A2 A3 M1 M2 X1 X2 X3. It supplies the state strobes the ALU consumes (`a12`, `m12`, `x12`, `x21_clk2`, `x31_clk2`) and the internal power-on clear.

---
 rtl/timing_pkg.sv | 31 +++
 rtl/phase_div.sv | 45 ++++
 rtl/timing_gen.sv | 130 +++++++++++++
 tb/tb_timing_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared machine-state and quarter encodings for the 4004 timing chain,
// plus the one-hot state decode also used by the decode board.
package timing_pkg;

    typedef enum logic [2:0] {
        ST_A1 = 3'd0,
        ST_A2 = 3'd1,
        ST_A3 = 3'd2,
        ST_M1 = 3'd3,
        ST_M2 = 3'd4,
        ST_X1 = 3'd5,
        ST_X2 = 3'd6,
        ST_X3 = 3'd7
    } mstate_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_t;

    // Bit n is set for machine state n, so bit 0 is A1 and bit 7 is X3.
    function automatic logic [7:0] state_onehot(input mstate_t s);
        logic [7:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/phase_div.sv
// Tick and quarter counters: divides sysclk into four quarters per state
// and flags the edge on which the machine state must advance.
import timing_pkg::*;

module phase_div #(
    parameter int TICKS_PER_PHASE = 1
) (
    input  logic     sysclk,
    input  logic     poc,
    output quarter_t quarter,
    output quarter_t quarter_nxt,
    output logic     state_adv
);

    localparam int TW = (TICKS_PER_PHASE > 1) ? $clog2(TICKS_PER_PHASE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_PHASE - 1);

    logic [TW-1:0] tick;
    logic [TW-1:0] tick_nxt;
    logic          tick_wrap;

    always_comb begin
        tick_wrap   = (tick == TICK_LAST);
        tick_nxt    = tick;
        quarter_nxt = quarter;
        if (tick_wrap) begin
            tick_nxt    = '0;
            quarter_nxt = quarter_t'(quarter + 2'd1);
        end else begin
            tick_nxt    = tick + 1'b1;
        end
        state_adv = tick_wrap && (quarter == Q3);
    end

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            tick    <= '0;
            quarter <= Q0;
        end else begin
            tick    <= tick_nxt;
            quarter <= quarter_nxt;
        end
    end

endmodule

// File: rtl/timing_gen.sv
// 4004 machine-cycle timing generator: two-phase clocks, state strobes,
// power-on clear stretch and once-per-cycle TEST sampling.
//
//  state | meaning
//  ------+------------------------------------------
//  A1    | address nibble 1 out, a12 high
//  A2    | address nibble 2 out, a22 high
//  A3    | address nibble 3 out, a32 high
//  M1    | opcode high nibble in, m12 high
//  M2    | opcode low nibble in, m22 high
//  X1    | execute 1, x12 high
//  X2    | execute 2, x22 high, x21_clk2 strobe in q2
//  X3    | execute 3, x32 high, sync_n low, TEST sampled at q2
import timing_pkg::*;

module timing_gen #(
    parameter int TICKS_PER_PHASE = 1,
    parameter int POC_CYCLES      = 8
) (
    input  logic sysclk,
    input  logic poc,
    input  logic test_i,
    output logic clk1,
    output logic clk2,
    output logic a12,
    output logic a22,
    output logic a32,
    output logic m12,
    output logic m22,
    output logic x12,
    output logic x22,
    output logic x32,
    output logic x21_clk2,
    output logic x31_clk2,
    output logic sync_n,
    output logic poc_o,
    output logic test_o
);

    localparam int PW = $clog2(POC_CYCLES + 1);
    localparam logic [PW-1:0] POC_LAST = PW'(POC_CYCLES);

    quarter_t      quarter;
    quarter_t      quarter_nxt;
    logic          state_adv;
    mstate_t       state;
    mstate_t       state_nxt;
    logic [PW-1:0] poc_cnt;
    logic [PW-1:0] poc_cnt_nxt;
    logic          test_s1;
    logic          test_s2;
    logic          x3q2_entry;
    logic [7:0]    flags;
    logic [7:0]    flags_nxt;
    logic          clk1_nxt;
    logic          clk2_nxt;
    logic          x21_nxt;
    logic          x31_nxt;
    logic          sync_n_nxt;
    logic          poc_o_nxt;
    logic          test_o_nxt;

    phase_div #(
        .TICKS_PER_PHASE(TICKS_PER_PHASE)
    ) u_phase_div (
        .sysclk      (sysclk),
        .poc         (poc),
        .quarter     (quarter),
        .quarter_nxt (quarter_nxt),
        .state_adv   (state_adv)
    );

    assign {x32, x22, x12, m22, m12, a32, a22, a12} = flags;

    // Every output is decoded from the next counter values and registered,
    // so it changes on the same edge as the counters and cannot glitch.
    always_comb begin
        state_nxt   = state;
        poc_cnt_nxt = poc_cnt;
        if (state_adv) begin
            state_nxt = mstate_t'(state + 3'd1);
            if ((state == ST_X3) && (poc_cnt != POC_LAST)) begin
                poc_cnt_nxt = poc_cnt + 1'b1;
            end
        end

        x3q2_entry = (state_nxt == ST_X3) && (quarter_nxt == Q2) &&
                     !((state == ST_X3) && (quarter == Q2));

        flags_nxt  = state_onehot(state_nxt);
        clk1_nxt   = (quarter_nxt == Q0);
        clk2_nxt   = (quarter_nxt == Q2);
        x21_nxt    = !((state_nxt == ST_X2) && (quarter_nxt == Q2));
        x31_nxt    = !((state_nxt == ST_X3) && (quarter_nxt == Q2));
        sync_n_nxt = (state_nxt != ST_X3);
        poc_o_nxt  = poc_o && (poc_cnt_nxt != POC_LAST);
        test_o_nxt = x3q2_entry ? test_s2 : test_o;
    end

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            state    <= ST_A1;
            poc_cnt  <= '0;
            test_s1  <= 1'b0;
            test_s2  <= 1'b0;
            flags    <= state_onehot(ST_A1);
            clk1     <= 1'b1;
            clk2     <= 1'b0;
            x21_clk2 <= 1'b1;
            x31_clk2 <= 1'b1;
            sync_n   <= 1'b1;
            poc_o    <= 1'b1;
            test_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            poc_cnt  <= poc_cnt_nxt;
            test_s1  <= test_i;
            test_s2  <= test_s1;
            flags    <= flags_nxt;
            clk1     <= clk1_nxt;
            clk2     <= clk2_nxt;
            x21_clk2 <= x21_nxt;
            x31_clk2 <= x31_nxt;
            sync_n   <= sync_n_nxt;
            poc_o    <= poc_o_nxt;
            test_o   <= test_o_nxt;
        end
    end

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen: one instance at one tick per phase and
// one at three ticks per phase, sharing clock, reset and TEST.
module tb_timing_gen;

    logic sysclk = 1'b0;
    logic poc    = 1'b0;
    logic test_i = 1'b0;

    logic s1_clk1, s1_clk2, s1_a12, s1_a22, s1_a32, s1_m12, s1_m22, s1_x12, s1_x22, s1_x32;
    logic s1_x21, s1_x31, s1_sync_n, s1_poc_o, s1_test_o;
    logic s3_clk1, s3_clk2, s3_a12, s3_a22, s3_a32, s3_m12, s3_m22, s3_x12, s3_x22, s3_x32;
    logic s3_x21, s3_x31, s3_sync_n, s3_poc_o, s3_test_o;

    timing_gen #(.TICKS_PER_PHASE(1), .POC_CYCLES(8)) dut1 (
        .sysclk(sysclk), .poc(poc), .test_i(test_i),
        .clk1(s1_clk1), .clk2(s1_clk2),
        .a12(s1_a12), .a22(s1_a22), .a32(s1_a32), .m12(s1_m12), .m22(s1_m22),
        .x12(s1_x12), .x22(s1_x22), .x32(s1_x32),
        .x21_clk2(s1_x21), .x31_clk2(s1_x31), .sync_n(s1_sync_n),
        .poc_o(s1_poc_o), .test_o(s1_test_o)
    );

    timing_gen #(.TICKS_PER_PHASE(3), .POC_CYCLES(8)) dut3 (
        .sysclk(sysclk), .poc(poc), .test_i(test_i),
        .clk1(s3_clk1), .clk2(s3_clk2),
        .a12(s3_a12), .a22(s3_a22), .a32(s3_a32), .m12(s3_m12), .m22(s3_m22),
        .x12(s3_x12), .x22(s3_x22), .x32(s3_x32),
        .x21_clk2(s3_x21), .x31_clk2(s3_x31), .sync_n(s3_sync_n),
        .poc_o(s3_poc_o), .test_o(s3_test_o)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int         edge_n;
        logic       tst;
        logic       c1;
        logic       c2;
        logic [7:0] flags;
        logic       x21;
        logic       x31;
        logic       syn;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   ecnt     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic goto_edge(input int target);
        while (ecnt < target) begin
            @(negedge sysclk);
            ecnt++;
        end
    endtask

    function automatic logic [7:0] flags1();
        return {s1_x32, s1_x22, s1_x12, s1_m22, s1_m12, s1_a32, s1_a22, s1_a12};
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_clk1"},   32'(s1_clk1),   32'd1);
        chk({tag, "_clk2"},   32'(s1_clk2),   32'd0);
        chk({tag, "_flags"},  32'(flags1()),  32'h01);
        chk({tag, "_x21"},    32'(s1_x21),    32'd1);
        chk({tag, "_x31"},    32'(s1_x31),    32'd1);
        chk({tag, "_sync_n"}, 32'(s1_sync_n), 32'd1);
        chk({tag, "_poc_o"},  32'(s1_poc_o),  32'd1);
        chk({tag, "_test_o"}, 32'(s1_test_o), 32'd0);
        chk({tag, "_a12_3"},  32'(s3_a12),    32'd1);
        chk({tag, "_clk1_3"}, 32'(s3_clk1),   32'd1);
    endtask

    initial begin
        int vi;
        int m1;
        int m3;
        int b;

        //         edge tst c1 c2 flags  x21 x31 syn
        vecs.push_back('{0,  1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1,  1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{2,  1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{3,  1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{4,  1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{6,  1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{8,  1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{12, 1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{18, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{20, 1'b0, 1'b1, 1'b0, 8'h20, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{26, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{27, 1'b0, 1'b0, 1'b0, 8'h40, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{28, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{30, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{31, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{32, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1});

        // Power-on reset: asynchronous response before any clock edge.
        #2 poc = 1'b1;
        #2 chk_reset("por");
        @(negedge sysclk);
        poc  = 1'b0;
        ecnt = 0;

        vi = 0;
        for (int e = 0; e <= 256; e++) begin
            goto_edge(e);
            if (vi < vecs.size() && vecs[vi].edge_n == e) begin
                test_i = vecs[vi].tst;
                chk("vec_clk1",   32'(s1_clk1),   32'(vecs[vi].c1));
                chk("vec_clk2",   32'(s1_clk2),   32'(vecs[vi].c2));
                chk("vec_flags",  32'(flags1()),  32'(vecs[vi].flags));
                chk("vec_x21",    32'(s1_x21),    32'(vecs[vi].x21));
                chk("vec_x31",    32'(s1_x31),    32'(vecs[vi].x31));
                chk("vec_sync_n", 32'(s1_sync_n), 32'(vecs[vi].syn));
                vi++;
            end
            m1 = e % 32;
            m3 = e % 96;
            chk("t1_clk1",    32'(s1_clk1),          32'(m1 % 4 == 0));
            chk("t1_clk2",    32'(s1_clk2),          32'(m1 % 4 == 2));
            chk("t1_overlap", 32'(s1_clk1 & s1_clk2), 32'd0);
            chk("t1_sync_n",  32'(s1_sync_n),        32'(m1 < 28));
            chk("t1_x21",     32'(s1_x21),           32'(m1 != 26));
            chk("t1_x31",     32'(s1_x31),           32'(m1 != 30));
            chk("t1_poc_o",   32'(s1_poc_o),         32'(e < 256));
            chk("t3_clk1",    32'(s3_clk1),          32'((m3 % 12) < 3));
            chk("t3_clk2",    32'(s3_clk2),          32'(((m3 % 12) >= 6) && ((m3 % 12) < 9)));
            chk("t3_overlap", 32'(s3_clk1 & s3_clk2), 32'd0);
            chk("t3_sync_n",  32'(s3_sync_n),        32'(m3 < 84));
            chk("t3_x31",     32'(s3_x31),           32'(!((m3 >= 90) && (m3 < 93))));
            chk("t3_a12",     32'(s3_a12),           32'(m3 < 12));
        end
        chk("vec_all_applied", 32'(vi), 32'(vecs.size()));
        chk("poc_fall_a12", 32'(s1_a12), 32'd1);

        // TEST raised during X1 is seen at X3 q2 of the same cycle.
        b = 256;
        goto_edge(b + 21);
        test_i = 1'b1;
        goto_edge(b + 29);
        chk("test_x1_before", 32'(s1_test_o), 32'd0);
        goto_edge(b + 30);
        chk("test_x1_load", 32'(s1_test_o), 32'd1);
        goto_edge(b + 31);
        test_i = 1'b0;
        goto_edge(b + 61);
        chk("test_hold", 32'(s1_test_o), 32'd1);
        goto_edge(b + 62);
        chk("test_clear", 32'(s1_test_o), 32'd0);

        // TEST raised one edge before X3 q2 misses this cycle.
        b = 320;
        goto_edge(b + 29);
        test_i = 1'b1;
        goto_edge(b + 30);
        chk("test_late_miss", 32'(s1_test_o), 32'd0);
        goto_edge(b + 61);
        chk("test_late_hold", 32'(s1_test_o), 32'd0);
        goto_edge(b + 62);
        chk("test_late_load", 32'(s1_test_o), 32'd1);

        // Single-period poc pulse during M2 q2.
        b = 384;
        goto_edge(b + 18);
        chk("mid_pre_m22",  32'(s1_m22),  32'd1);
        chk("mid_pre_clk2", 32'(s1_clk2), 32'd1);
        #1 poc = 1'b1;
        #1 chk_reset("mid");
        @(negedge sysclk);
        poc  = 1'b0;
        ecnt = 0;
        chk_reset("mid_rel");
        goto_edge(1);
        chk("mid_q1_clk1", 32'(s1_clk1), 32'd0);
        goto_edge(255);
        chk("mid_poc_hold", 32'(s1_poc_o), 32'd1);
        goto_edge(256);
        chk("mid_poc_fall", 32'(s1_poc_o), 32'd0);
        chk("mid_poc_a12",  32'(s1_a12),   32'd1);
        chk("mid_poc3_hold", 32'(s3_poc_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
